// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI-Stream FIFO family.
//   AXIS_FIFO_ENTRY_T(DW) : packed storage entry {last, data[DW-1:0]}
//   level_width()         : width of fill-level / packet counters (AWIDTH+1)
//   entry_width()         : bit width of one stored entry (DWIDTH+1)
//   rel_state_e           : packet-mode release state, exported for debug
`define AXIS_FIFO_ENTRY_T(DW) struct packed { logic last; logic [(DW)-1:0] data; }

package axis_fifo_pkg;

  // REL_STORE: store-and-forward, output waits for a complete packet.
  // REL_DRAIN: an oversized packet filled the FIFO and drains cut-through.
  typedef enum logic {
    REL_STORE = 1'b0,
    REL_DRAIN = 1'b1
  } rel_state_e;

  // Counters must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int level_width(input int awidth);
    return awidth + 1;
  endfunction

  function automatic int entry_width(input int dwidth);
    return dwidth + 1;
  endfunction

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast).
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; the master holds tdata/tlast stable while tvalid is high and
// tready is low.
//   master modport : drives tdata, tvalid, tlast; samples tready
//   slave modport  : samples tdata, tvalid, tlast; drives tready
interface axis_sync_fifo_if #(
  parameter int DWIDTH = 8
) ();
  logic [DWIDTH-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_fifo_mem.sv
// DEPTH x WIDTH register array, one clocked write port and one asynchronous
// read port. No reset: contents are only meaningful where pointers say so.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data, combinational from raddr_i
module axis_fifo_mem #(
  parameter int AWIDTH = 4,
  parameter int WIDTH  = 9
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with registered fill level, programmable
// almost-full/almost-empty thresholds, complete-packet counting and an
// optional store-and-forward packet mode.
//   clk, res            : clock, synchronous active-high reset
//   s_axis (slave)      : write stream; tready = !full
//   m_axis (master)     : read stream, first-word-fall-through head entry
//   af_thresh/ae_thresh : almost-full / almost-empty thresholds
//   level, pkt_count    : stored entries, stored tlast beats
//   full, empty, almost_full, almost_empty : registered level flags
//   pkt_oversize        : sticky, packet mode had to release an incomplete packet
//   dbg_state_o         : packet-mode release state
module axis_sync_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DWIDTH      = 8,
  parameter int AWIDTH      = 4,
  parameter int PACKET_MODE = 0
) (
  input  logic              clk,
  input  logic              res,
  axis_sync_fifo_if.slave   s_axis,
  axis_sync_fifo_if.master  m_axis,
  input  logic [AWIDTH:0]   af_thresh,
  input  logic [AWIDTH:0]   ae_thresh,
  output logic [AWIDTH:0]   level,
  output logic [AWIDTH:0]   pkt_count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              pkt_oversize,
  output rel_state_e        dbg_state_o
);
  localparam int LW    = level_width(AWIDTH);
  localparam int EW    = entry_width(DWIDTH);
  localparam int DEPTH = 1 << AWIDTH;

  typedef `AXIS_FIFO_ENTRY_T(DWIDTH) entry_t;

  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     pkt_q, pkt_d;
  logic              full_q, empty_q, af_q, ae_q, ovs_q;
  rel_state_e        state_q;
  entry_t            wr_entry, rd_entry;
  logic              wr, rd, m_valid, rel_set;

  // tready depends only on registered state, never on m_axis.tready.
  assign s_axis.tready = !full_q;
  assign wr            = s_axis.tvalid & !full_q;
  assign wr_entry      = {s_axis.tlast, s_axis.tdata};

  axis_fifo_mem #(
    .AWIDTH (AWIDTH),
    .WIDTH  (EW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  // Cut-through presents any stored beat; packet mode additionally needs a
  // complete packet stored or an oversize release in progress.
  assign m_valid = !empty_q &
                   ((PACKET_MODE == 0) | (pkt_q != '0) | (state_q == REL_DRAIN));
  assign rd      = m_valid & m_axis.tready;

  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = rd_entry.data;
  assign m_axis.tlast  = rd_entry.last;

  assign level_d = level_q + LW'(wr) - LW'(rd);
  assign pkt_d   = pkt_q + LW'(wr & s_axis.tlast) - LW'(rd & rd_entry.last);

  // Evaluated on next-state values so the release takes effect in the same
  // cycle the FIFO reports full with no complete packet.
  assign rel_set = (PACKET_MODE != 0) && (level_d == LW'(DEPTH)) && (pkt_d == '0);

  always_ff @(posedge clk) begin
    if (res) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      pkt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovs_q   <= 1'b0;
      state_q <= REL_STORE;
    end else begin
      if (wr) wptr_q <= wptr_q + AWIDTH'(1);
      if (rd) rptr_q <= rptr_q + AWIDTH'(1);
      level_q <= level_d;
      pkt_q   <= pkt_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
      af_q    <= (level_d >= af_thresh);
      ae_q    <= (level_d <= ae_thresh);
      if (rel_set) ovs_q <= 1'b1;
      case (state_q)
        REL_STORE: if (rel_set) state_q <= REL_DRAIN;
        REL_DRAIN: if (!rel_set && rd && rd_entry.last) state_q <= REL_STORE;
        default:   state_q <= REL_STORE;
      endcase
    end
  end

  assign level        = level_q;
  assign pkt_count    = pkt_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign pkt_oversize = ovs_q;
  assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_axis_sync_fifo.sv
module tb_axis_sync_fifo;
  import axis_fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int LW    = AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic chk_en = 1'b0;

  // stimulus, index 0 = cut-through DUT, index 1 = packet-mode DUT
  logic          res_a      [2];
  logic          s_tvalid_a [2];
  logic [DW-1:0] s_tdata_a  [2];
  logic          s_tlast_a  [2];
  logic          m_tready_a [2];
  logic [LW-1:0] af_thresh, ae_thresh;

  // observed outputs
  logic          s_tready_a [2];
  logic          m_tvalid_a [2];
  logic          m_tlast_a  [2];
  logic [DW-1:0] m_tdata_a  [2];
  logic [LW-1:0] level_a    [2];
  logic [LW-1:0] pkt_a      [2];
  logic          full_a [2], empty_a [2], af_a [2], ae_a [2], ovs_a [2];
  rel_state_e    dbg_a  [2];

  task automatic check(input string name, input int dut, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d: got %0h expected %0h at t=%0t", name, dut, act, exp, $time);
    end
  endtask

  // ---------------- DUTs + behavioural models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int PM = g;

    axis_sync_fifo_if #(.DWIDTH(DW)) s_if ();
    axis_sync_fifo_if #(.DWIDTH(DW)) m_if ();

    assign s_if.tdata   = s_tdata_a[g];
    assign s_if.tvalid  = s_tvalid_a[g];
    assign s_if.tlast   = s_tlast_a[g];
    assign m_if.tready  = m_tready_a[g];
    assign s_tready_a[g] = s_if.tready;
    assign m_tvalid_a[g] = m_if.tvalid;
    assign m_tdata_a[g]  = m_if.tdata;
    assign m_tlast_a[g]  = m_if.tlast;

    axis_sync_fifo #(
      .DWIDTH      (DW),
      .AWIDTH      (AW),
      .PACKET_MODE (PM)
    ) u_dut (
      .clk          (clk),
      .res          (res_a[g]),
      .s_axis       (s_if),
      .m_axis       (m_if),
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh),
      .level        (level_a[g]),
      .pkt_count    (pkt_a[g]),
      .full         (full_a[g]),
      .empty        (empty_a[g]),
      .almost_full  (af_a[g]),
      .almost_empty (ae_a[g]),
      .pkt_oversize (ovs_a[g]),
      .dbg_state_o  (dbg_a[g])
    );

    // Model: a queue of {last,data} beats plus release/oversize flags.
    logic [DW:0] mq [$];
    bit rel = 1'b0, ovs = 1'b0, e_af = 1'b0, e_ae = 1'b1;

    function automatic int npk();
      int n = 0;
      foreach (mq[i]) n += int'(mq[i][DW]);
      return n;
    endfunction

    function automatic bit exp_valid();
      if (mq.size() == 0) return 1'b0;
      if (PM == 0) return 1'b1;
      return (npk() != 0) || rel;
    endfunction

    always @(posedge clk) begin
      bit wr, rd, v;
      logic [DW:0] h;
      if (res_a[g]) begin
        mq.delete();
        rel  = 1'b0;
        ovs  = 1'b0;
        e_af = 1'b0;
        e_ae = 1'b1;
      end else begin
        v  = exp_valid();
        wr = s_tvalid_a[g] && (mq.size() < DEPTH);
        rd = v && m_tready_a[g];
        if (rd) begin
          h = mq.pop_front();
          if (h[DW]) rel = 1'b0;
        end
        if (wr) mq.push_back({s_tlast_a[g], s_tdata_a[g]});
        if (PM == 1 && mq.size() == DEPTH && npk() == 0) begin
          rel = 1'b1;
          ovs = 1'b1;
        end
        e_af = (mq.size() >= int'(af_thresh));
        e_ae = (mq.size() <= int'(ae_thresh));
      end
    end

    // Per-cycle scoreboard compare, away from the active edge.
    always @(negedge clk) begin
      if (chk_en) begin
        int n;
        n = mq.size();
        check("level",        g, level_a[g],    n);
        check("pkt_count",    g, pkt_a[g],      npk());
        check("full",         g, full_a[g],     n == DEPTH);
        check("empty",        g, empty_a[g],    n == 0);
        check("almost_full",  g, af_a[g],       e_af);
        check("almost_empty", g, ae_a[g],       e_ae);
        check("s_tready",     g, s_tready_a[g], n != DEPTH);
        check("m_tvalid",     g, m_tvalid_a[g], exp_valid());
        check("pkt_oversize", g, ovs_a[g],      ovs);
        check("dbg_state",    g, int'(dbg_a[g]), rel ? int'(REL_DRAIN) : int'(REL_STORE));
        if (exp_valid()) begin
          check("m_tdata", g, m_tdata_a[g], mq[0][DW-1:0]);
          check("m_tlast", g, m_tlast_a[g], mq[0][DW]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_s(input int d, input logic v, input logic [DW-1:0] data, input logic last);
    s_tvalid_a[d] = v;
    s_tdata_a[d]  = data;
    s_tlast_a[d]  = last;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] prev;
    int idx, nread, last_at;

    for (int d = 0; d < 2; d++) begin
      res_a[d] = 1'b1;
      drive_s(d, 1'b0, '0, 1'b0);
      m_tready_a[d] = 1'b0;
    end
    af_thresh = 3'd3;
    ae_thresh = 3'd1;
    repeat (2) step();
    res_a[0] = 1'b0;
    res_a[1] = 1'b0;
    chk_en   = 1'b1;

    // reset values
    for (int d = 0; d < 2; d++) begin
      check("rst_level", d, level_a[d], 0);
      check("rst_empty", d, empty_a[d], 1);
      check("rst_full",  d, full_a[d], 0);
      check("rst_ae",    d, ae_a[d], 1);
      check("rst_af",    d, af_a[d], 0);
      check("rst_tvalid", d, m_tvalid_a[d], 0);
      check("rst_ovs",   d, ovs_a[d], 0);
    end

    // 1: fill to full, reject 5th beat, drain in order
    for (int i = 0; i < 4; i++) begin
      drive_s(0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0);
      step();
    end
    check("t1_level4", 0, level_a[0], 4);
    check("t1_full",   0, full_a[0], 1);
    check("t1_tready", 0, s_tready_a[0], 0);
    drive_s(0, 1'b1, 8'h55, 1'b0);
    step();
    check("t1_no5th", 0, level_a[0], 4);
    drive_s(0, 1'b0, '0, 1'b0);
    m_tready_a[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t1_rvalid", 0, m_tvalid_a[0], 1);
      check("t1_rdata",  0, m_tdata_a[0], 8'h11 * (i + 1));
      step();
    end
    check("t1_empty", 0, empty_a[0], 1);
    check("t1_level0", 0, level_a[0], 0);

    // 2: continuous streaming, one-cycle delay, pointer wrap
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        check("t2_level", 0, level_a[0], 1);
        check("t2_data",  0, m_tdata_a[0], prev);
      end
      prev = 8'($urandom_range(0, 255));
      drive_s(0, 1'b1, prev, 1'($urandom_range(0, 1)));
      step();
    end
    drive_s(0, 1'b0, '0, 1'b0);
    step();
    m_tready_a[0] = 1'b0;
    step();

    // 3: thresholds af=3, ae=1 while filling and draining
    for (int i = 0; i <= 4; i++) begin
      check("t3_fill_level", 0, level_a[0], i);
      check("t3_fill_ae",    0, ae_a[0], i <= 1);
      check("t3_fill_af",    0, af_a[0], i >= 3);
      drive_s(0, i < 4, 8'(i), 1'b0);
      step();
    end
    m_tready_a[0] = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      check("t3_drain_level", 0, level_a[0], i);
      check("t3_drain_ae",    0, ae_a[0], i <= 1);
      check("t3_drain_af",    0, af_a[0], i >= 3);
      step();
    end
    m_tready_a[0] = 1'b0;

    // 4: packet mode, output held until tlast is stored
    m_tready_a[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t4_hold", 1, m_tvalid_a[1], 0);
      drive_s(1, 1'b1, 8'(8'hA0 + i), i == 2);
      step();
    end
    drive_s(1, 1'b0, '0, 1'b0);
    check("t4_valid", 1, m_tvalid_a[1], 1);
    check("t4_d0",    1, m_tdata_a[1], 8'hA0);
    check("t4_pkt1",  1, pkt_a[1], 1);
    step();
    check("t4_d1",    1, m_tdata_a[1], 8'hA1);
    step();
    check("t4_d2",    1, m_tdata_a[1], 8'hA2);
    check("t4_last",  1, m_tlast_a[1], 1);
    step();
    check("t4_pkt0",  1, pkt_a[1], 0);
    check("t4_done",  1, m_tvalid_a[1], 0);

    // 5: oversize packet forces release
    m_tready_a[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_hold", 1, m_tvalid_a[1], 0);
      drive_s(1, 1'b1, 8'(8'hB0 + i), 1'b0);
      step();
    end
    drive_s(1, 1'b0, '0, 1'b0);
    check("t5_level", 1, level_a[1], 4);
    check("t5_pkt",   1, pkt_a[1], 0);
    check("t5_ovs",   1, ovs_a[1], 1);
    check("t5_valid", 1, m_tvalid_a[1], 1);
    m_tready_a[1] = 1'b1;
    idx = 4; nread = 0; last_at = -1;
    for (int c = 0; c < 40; c++) begin
      if (nread == 6) break;
      if (m_tvalid_a[1]) begin
        check("t5_data", 1, m_tdata_a[1], 8'hB0 + nread);
        if (m_tlast_a[1]) last_at = nread;
        nread++;
      end
      drive_s(1, idx < 6, 8'(8'hB0 + idx), idx == 5);
      if (idx < 6 && s_tready_a[1]) idx++;
      step();
    end
    drive_s(1, 1'b0, '0, 1'b0);
    check("t5_nread",  1, nread, 6);
    check("t5_lastat", 1, last_at, 5);
    check("t5_ovs_sticky", 1, ovs_a[1], 1);
    check("t5_empty",  1, empty_a[1], 1);

    // 6: reset mid-traffic discards contents
    m_tready_a[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_s(1, 1'b1, 8'(8'hC0 + i), i == 2);
      step();
    end
    check("t6_level3", 1, level_a[1], 3);
    check("t6_pkt1",   1, pkt_a[1], 1);
    res_a[1] = 1'b1;
    drive_s(1, 1'b1, 8'hEE, 1'b1);
    m_tready_a[1] = 1'b1;
    step();
    res_a[1] = 1'b0;
    check("t6_level0", 1, level_a[1], 0);
    check("t6_pkt0",   1, pkt_a[1], 0);
    check("t6_empty",  1, empty_a[1], 1);
    check("t6_valid0", 1, m_tvalid_a[1], 0);
    check("t6_ovs0",   1, ovs_a[1], 0);
    drive_s(1, 1'b1, 8'h5A, 1'b1);
    step();
    drive_s(1, 1'b0, '0, 1'b0);
    check("t6_valid", 1, m_tvalid_a[1], 1);
    check("t6_data",  1, m_tdata_a[1], 8'h5A);
    step();
    check("t6_drained", 1, empty_a[1], 1);

    // random traffic on both DUTs, thresholds varied, boundary thresholds last
    for (int cyc = 0; cyc < 1200; cyc++) begin
      if (cyc % 150 == 0 && cyc < 1000) begin
        af_thresh = LW'($urandom_range(0, 5));
        ae_thresh = LW'($urandom_range(0, 5));
      end
      if (cyc == 1000) begin
        af_thresh = 3'd5;
        ae_thresh = 3'd4;
      end
      for (int d = 0; d < 2; d++) begin
        res_a[d] = ($urandom_range(0, 99) == 0);
        drive_s(d, $urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
                $urandom_range(0, 3) == 0);
        m_tready_a[d] = ($urandom_range(0, 2) != 0);
      end
      step();
      if (cyc > 1001) begin
        check("bnd_af_never", 0, af_a[0], 0);
        check("bnd_ae_always", 1, ae_a[1], 1);
      end
    end
    for (int d = 0; d < 2; d++) begin
      res_a[d] = 1'b0;
      drive_s(d, 1'b0, '0, 1'b0);
      m_tready_a[d] = 1'b1;
    end
    repeat (8) step();
    check("end_empty0", 0, empty_a[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
- Single-clock, parametrised FIFO with AXI-Stream slave and master ports (tvalid/tready/tlast).
- Successor to the flag-only simple FIFO. Adds:
  - true 2**AWIDTH depth;
  - a registered fill level and programmable almost-full/almost-empty thresholds;
  - complete-packet counting;
  - optional store-and-forward packet mode.
- Sits between the AstroPix readout/decoder stream sources and the AXIS switch inputs, buffering hit frames.

Parameters:
- DWIDTH, 8, tdata width in bits.
- AWIDTH, 4, address width; DEPTH = 2**AWIDTH entries, and all DEPTH entries are usable.
- PACKET_MODE, 0, 0 = cut-through (FWFT); 1 = store-and-forward, so the output presents data only once a complete packet (tlast) is stored.

Ports:
- clk, in, 1, single clock; all logic on its rising edge.
- res, in, 1, synchronous active-high reset.
- s_axis_tdata, in, DWIDTH, write data.
- s_axis_tvalid, in, 1, write data valid.
- s_axis_tlast, in, 1, last beat of packet.
- s_axis_tready, out, 1, FIFO can accept a beat.
- m_axis_tdata, out, DWIDTH, head-of-FIFO data.
- m_axis_tvalid, out, 1, head data presentable.
- m_axis_tlast, out, 1, tlast stored with the head entry.
- m_axis_tready, in, 1, consumer accepts the beat.
- af_thresh, in, AWIDTH+1, almost-full threshold; quasi-static.
- ae_thresh, in, AWIDTH+1, almost-empty threshold; quasi-static.
- level, out, AWIDTH+1, entries stored, 0..DEPTH.
- pkt_count, out, AWIDTH+1, complete packets stored (stored tlast beats).
- full, out, 1, level == DEPTH.
- empty, out, 1, level == 0.
- almost_full, out, 1, level >= af_thresh.
- almost_empty, out, 1, level <= ae_thresh.
- pkt_oversize, out, 1, sticky: packet mode was forced to release because the FIFO filled with no complete packet.

Behaviour:
- Handshake events:
  - wr = s_axis_tvalid & s_axis_tready.
  - rd = m_axis_tvalid & m_axis_tready.
- s_axis_tready = !full. It is a pure decode of the registered full, with no combinational path from m_axis_tready.
- Storage:
  - Each entry holds {tlast, tdata}.
  - On wr: mem[wptr] <= {s_axis_tlast, s_axis_tdata}, wptr <= wptr+1.
  - On rd: rptr <= rptr+1.
  - Pointers are AWIDTH bits and wrap naturally at DEPTH.
- Head output: m_axis_tdata and m_axis_tlast come from mem[rptr] combinationally (FWFT). Data is valid while m_axis_tvalid is high and stays stable until rd.
- level update:
  - level <= level + wr - rd.
  - Simultaneous wr and rd leaves it unchanged.
  - wr is impossible at DEPTH; rd is impossible at 0.
- pkt_count update:
  - pkt_count <= pkt_count + (wr & s_axis_tlast) - (rd & m_axis_tlast).
  - Both events in one cycle leave it unchanged.
- Registered flags:
  - full, empty, almost_full and almost_empty are registered.
  - Each is computed from the next-level value, so all flags change in the same cycle as level. There are no stale flags.
- m_axis_tvalid:
  - PACKET_MODE=0: m_axis_tvalid = !empty.
  - PACKET_MODE=1: m_axis_tvalid = !empty & (pkt_count != 0 | release).
- Oversize release (PACKET_MODE=1 only):
  - release is set when full & pkt_count==0; this condition also sets pkt_oversize.
  - release clears on rd of an entry with tlast=1.
  - The oversized packet drains cut-through, then store-and-forward resumes.
- Latency:
  - PACKET_MODE=0: a beat written in cycle N gives m_axis_tvalid high in N+1.
  - PACKET_MODE=1: tvalid rises in the cycle after the tlast beat is written.
- Write into an empty FIFO with m_axis_tready high: the beat appears in N+1 and is consumed then. There is no bypass path.
- Thresholds: af_thresh > DEPTH means almost_full is never asserted. ae_thresh >= DEPTH means almost_empty is always asserted.
- Reset values (res=1 on a clock edge):
  - wptr=rptr=0, level=0, pkt_count=0.
  - empty=1, full=0, almost_full=0.
  - almost_empty = (ae_thresh >= 0) = 1.
  - release=0, pkt_oversize=0, m_axis_tvalid=0.
- Reset mid-packet discards all contents, including partial packets. Memory contents are not cleared.
- Flags are evaluated in the first cycle after reset.

Decomposition:
- Package axis_fifo_pkg holds:
  - a function returning level width (AWIDTH+1);
  - the entry-packing typedef {logic last; logic [DWIDTH-1:0] data} (parametrised via a macro or localparam struct width).
- One sub-module: axis_fifo_mem.
  - Simple 1W/1R-async register array of DEPTH x (DWIDTH+1).
  - Write port clocked, read port combinational.
  - It is reusable by the multi-channel variant.

Test Plan:
1. PACKET_MODE=0, DWIDTH=8, AWIDTH=2:
   - Stimulus: write 0x11,0x22,0x33,0x44 with m_axis_tready=0.
   - Required: full=1, level=4 and s_axis_tready=0 after the 4th write; a 5th beat 0x55 is not accepted.
   - Then hold m_axis_tready=1: output reads 0x11..0x44 in order, then empty=1, level=0.
2. Continuous streaming with tvalid=tready=1 for 20 cycles from empty:
   - level stays at 1 after the first cycle.
   - The output sequence equals the input sequence delayed 1 cycle, including across pointer wrap.
3. Thresholds af_thresh=3, ae_thresh=1, AWIDTH=2:
   - Fill 0 to 4: almost_empty high at level 0..1; almost_full rises in the same cycle level becomes 3.
   - Drain back: flags track symmetrically.
4. PACKET_MODE=1:
   - Stimulus: write 3 beats 0xA0,0xA1,0xA2 (tlast on 0xA2) with m_axis_tready=1.
   - Required: m_axis_tvalid stays 0 until the cycle after 0xA2 is written, then 3 beats appear with tlast on 0xA2; pkt_count goes 1 to 0.
5. PACKET_MODE=1, AWIDTH=2:
   - Stimulus: write 6-beat packet.
   - Required: at level=4 with pkt_count=0, pkt_oversize=1 and tvalid rises; the packet drains fully, including tlast; pkt_oversize stays 1 until res.
6. Fill to level=3 with one complete packet, then assert res for one cycle with tvalid/tready active:
   - Required: the next cycle shows level=0, pkt_count=0, empty=1, m_axis_tvalid=0; a subsequent write of 0x5A reads back as 0x5A.
